uart_rx: RTL and testbench

UART receiver for the icesugar board, clocked from the PLL's `uart_clk` output (100.5 MHz). It turns the asynchronous serial `rx` pin (8 data bits, no parity, 1 stop bit, LSB first) into bytes on a valid/ready stream toward the core. It synchronizes the pin, validates the start bit at mid-bit, and flags framing errors. It also holds one received byte until it is consumed and reports overruns.

---
 rtl/uart_rx.sv | 149 ++++++++++++++
 tb/tb_uart_rx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and a one-byte holding register
//
// Ports:
//   clock       in   receive clock, all logic on its rising edge
//   reset       in   synchronous, active-high
//   rx          in   asynchronous serial line, idles high
//   data        out  received byte, stable while valid
//   valid       out  data holds an unconsumed byte
//   ready       in   consumer takes the byte when valid && ready
//   frame_error out  one-cycle pulse: stop bit sampled low
//   overrun     out  one-cycle pulse: good byte dropped, holding register full
//   busy        out  receiver is not idle (registered)
module uart_rx #(
  parameter int CLKS_PER_BIT = 872
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_error,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int H  = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BRK
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          rx_meta;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          sample_bit;
  logic          stop_good;
  logic          stop_bad;
  // Stop-bit verdicts are registered once so the holding register and the
  // error pulses update on the edge after the stop sample.
  logic          good_q;
  logic          bad_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    sample_bit = 1'b0;
    stop_good  = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_s) state_next = S_START;
      end
      S_START: begin
        // A start bit that is high again at mid-bit was a glitch.
        if (cnt == CNT_HALF) state_next = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (cnt == CNT_LAST) begin
          sample_bit = 1'b1;
          if (bit_idx == 3'd7) state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt == CNT_LAST) begin
          if (rx_s) begin
            stop_good  = 1'b1;
            state_next = S_IDLE;
          end else begin
            stop_bad   = 1'b1;
            state_next = S_BRK;
          end
        end
      end
      S_BRK: begin
        // Wait out a held-low line so it reports only one frame error.
        if (rx_s) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      cnt         <= '0;
      bit_idx     <= 3'd0;
      shift       <= 8'h00;
      good_q      <= 1'b0;
      bad_q       <= 1'b0;
      data        <= 8'h00;
      valid       <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;

      // Counter restarts on every state change and after each data sample,
      // and rests at zero while waiting for a line level.
      if (state_next != state || sample_bit || state == S_IDLE || state == S_BRK) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end

      if (sample_bit) begin
        shift   <= {rx_s, shift[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end

      good_q      <= stop_good;
      bad_q       <= stop_bad;
      frame_error <= bad_q;
      overrun     <= good_q && valid && !ready;
      busy        <= (state != S_IDLE);

      // A byte consumed in the same cycle frees the register for the new one.
      if (good_q && (!valid || ready)) begin
        data  <= shift;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized and directed bench for uart_rx against a frame-level reference model
module tb_uart_rx;

  localparam int C     = 8;
  localparam int H     = C / 2;
  localparam int CD    = 872;
  localparam int CD_SL = 898;
  // Cycles from driving the start edge on the pin to the output update:
  // 2 synchronizer cycles + 1 to reach t0, then H + 9 bit periods + 1.
  localparam int LAT   = 3 + H + 9 * C + 1;
  localparam int LAT_D = 3 + CD / 2 + 9 * CD + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_a, ready_a, valid_a, fe_a, ov_a, busy_a;
  logic [7:0] data_a;
  logic       rx_b, ready_b, valid_b, fe_b, ov_b, busy_b;
  logic [7:0] data_b;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clock(clk), .reset(reset), .rx(rx_a), .data(data_a), .valid(valid_a),
    .ready(ready_a), .frame_error(fe_a), .overrun(ov_a), .busy(busy_a)
  );

  uart_rx #(.CLKS_PER_BIT(CD)) dut_def (
    .clock(clk), .reset(reset), .rx(rx_b), .data(data_b), .valid(valid_b),
    .ready(ready_b), .frame_error(fe_b), .overrun(ov_b), .busy(busy_b)
  );

  int   hs_d[$], hs_t[$], vr_t[$], fe_t[$], ov_t[$], bz_t[$];
  int   hs2_d[$], hs2_t[$], fe2_t[$], ov2_t[$];
  logic valid_prev = 1'b0;

  always @(negedge clk) begin
    if (valid_a && ready_a) begin
      hs_d.push_back(int'(data_a));
      hs_t.push_back(cyc);
    end
    if (valid_a && !valid_prev) vr_t.push_back(cyc);
    valid_prev <= valid_a;
    if (fe_a) fe_t.push_back(cyc);
    if (ov_a) ov_t.push_back(cyc);
    if (busy_a) bz_t.push_back(cyc);
    if (valid_b && ready_b) begin
      hs2_d.push_back(int'(data_b));
      hs2_t.push_back(cyc);
    end
    if (fe_b) fe2_t.push_back(cyc);
    if (ov_b) ov2_t.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    hs_d.delete(); hs_t.delete(); vr_t.delete(); fe_t.delete(); ov_t.delete(); bz_t.delete();
    hs2_d.delete(); hs2_t.delete(); fe2_t.delete(); ov2_t.delete();
  endtask

  task automatic drive_bit(input bit which, input logic v, input int len);
    for (int i = 0; i < len; i++) begin
      if (which) rx_b = v;
      else rx_a = v;
      tick();
    end
  endtask

  task automatic send_frame(input bit which, input logic [7:0] b, input logic stop,
                            input int per, output int n);
    n = cyc;
    drive_bit(which, 1'b0, per);
    for (int k = 0; k < 8; k++) drive_bit(which, b[k], per);
    drive_bit(which, stop, per);
  endtask

  int         n, n2, n3, n4;
  int         exp_d[$], exp_t[$], exp_fe[$];
  logic [7:0] rb;
  logic       rbad;

  initial begin
    rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b1; ready_b = 1'b1; reset = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_data", 32'(data_a), 32'h0);
    check("rst_valid", 32'(valid_a), 32'h0);
    check("rst_fe", 32'(fe_a), 32'h0);
    check("rst_ov", 32'(ov_a), 32'h0);
    check("rst_busy", 32'(busy_a), 32'h0);
    tick();
    reset = 1'b0;
    repeat (4) tick();

    // Single byte
    clear_logs();
    send_frame(1'b0, 8'h55, 1'b1, C, n);
    repeat (20) tick();
    check("t1_count", hs_d.size(), 1);
    check("t1_data", hs_d.size() > 0 ? hs_d[0] : -1, 32'h55);
    check("t1_time", hs_t.size() > 0 ? hs_t[0] : -1, n + LAT);
    check("t1_busy_rise", bz_t.size() > 0 ? bz_t[0] : -1, n + 4);
    check("t1_busy_fall", bz_t.size() > 0 ? bz_t[$] : -1, n + LAT - 1);
    check("t1_no_fe", fe_t.size(), 0);

    // Glitch
    clear_logs();
    n = cyc;
    drive_bit(1'b0, 1'b0, 2);
    drive_bit(1'b0, 1'b1, 30);
    check("t2_busy_len", bz_t.size(), 4);
    check("t2_busy_rise", bz_t.size() > 0 ? bz_t[0] : -1, n + 4);
    check("t2_no_valid", hs_d.size(), 0);
    check("t2_no_fe", fe_t.size(), 0);

    // Framing error then a held-low line, then recovery
    clear_logs();
    send_frame(1'b0, 8'hA3, 1'b0, C, n);
    drive_bit(1'b0, 1'b0, 40);
    drive_bit(1'b0, 1'b1, 10);
    send_frame(1'b0, 8'h3C, 1'b1, C, n2);
    repeat (20) tick();
    check("t3_fe_count", fe_t.size(), 1);
    check("t3_fe_time", fe_t.size() > 0 ? fe_t[0] : -1, n + LAT);
    check("t3_rx_count", hs_d.size(), 1);
    check("t3_rx_data", hs_d.size() > 0 ? hs_d[0] : -1, 32'h3C);
    check("t3_rx_time", hs_t.size() > 0 ? hs_t[0] : -1, n2 + LAT);

    // Backpressure and overrun
    ready_a = 1'b0;
    clear_logs();
    send_frame(1'b0, 8'h11, 1'b1, C, n);
    send_frame(1'b0, 8'h22, 1'b1, C, n2);
    @(negedge clk);
    check("t4_valid_rise", vr_t.size() > 0 ? vr_t[0] : -1, n + LAT);
    check("t4_overrun", 32'(ov_a), 32'h1);
    check("t4_data_kept", 32'(data_a), 32'h11);
    check("t4_valid_held", 32'(valid_a), 32'h1);
    tick();
    ready_a = 1'b1;
    tick();
    ready_a = 1'b0;
    @(negedge clk);
    check("t4_valid_clear", 32'(valid_a), 32'h0);
    check("t4_ov_count", ov_t.size(), 1);
    check("t4_ov_time", ov_t.size() > 0 ? ov_t[0] : -1, n2 + LAT);
    check("t4_hs_data", hs_d.size() == 1 ? hs_d[0] : -1, 32'h11);
    tick();

    // Randomized frames, gaps and bad stop bits against the frame-level model
    ready_a = 1'b1;
    clear_logs();
    for (int i = 0; i < 16; i++) begin
      rb   = 8'($urandom);
      rbad = ($urandom_range(0, 4) == 0);
      send_frame(1'b0, rb, !rbad, C, n);
      if (rbad) begin
        exp_fe.push_back(n + LAT);
        drive_bit(1'b0, 1'b0, $urandom_range(0, 20));
        drive_bit(1'b0, 1'b1, $urandom_range(2, 10));
      end else begin
        exp_d.push_back(int'(rb));
        exp_t.push_back(n + LAT);
        drive_bit(1'b0, 1'b1, $urandom_range(0, 6));
      end
    end
    repeat (20) tick();
    check("rnd_count", hs_d.size(), exp_d.size());
    check("rnd_fe_count", fe_t.size(), exp_fe.size());
    for (int i = 0; i < exp_d.size() && i < hs_d.size(); i++) begin
      check($sformatf("rnd_data%0d", i), hs_d[i], exp_d[i]);
      check($sformatf("rnd_time%0d", i), hs_t[i], exp_t[i]);
    end
    for (int i = 0; i < exp_fe.size() && i < fe_t.size(); i++)
      check($sformatf("rnd_fe_time%0d", i), fe_t[i], exp_fe[i]);
    check("rnd_no_ov", ov_t.size(), 0);

    // Reset during data bit 3 of 0xF0
    drive_bit(1'b0, 1'b0, C);
    drive_bit(1'b0, 1'b0, 3 * C + C / 2);
    check("t5_busy_before", 32'(busy_a), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rx_a  = 1'b1;
    @(negedge clk);
    check("t5_data", 32'(data_a), 32'h0);
    check("t5_valid", 32'(valid_a), 32'h0);
    check("t5_fe", 32'(fe_a), 32'h0);
    check("t5_ov", 32'(ov_a), 32'h0);
    check("t5_busy", 32'(busy_a), 32'h0);
    clear_logs();
    repeat (100) tick();
    check("t5_no_valid", hs_d.size(), 0);
    check("t5_no_fe", fe_t.size(), 0);
    check("t5_idle", bz_t.size(), 0);

    // Default rate, back to back, nominal and 3% slow
    clear_logs();
    send_frame(1'b1, 8'h00, 1'b1, CD, n);
    send_frame(1'b1, 8'hFF, 1'b1, CD, n2);
    send_frame(1'b1, 8'h00, 1'b1, CD_SL, n3);
    send_frame(1'b1, 8'hFF, 1'b1, CD_SL, n4);
    repeat (20) tick();
    check("t6_count", hs2_d.size(), 4);
    check("t6_b0", hs2_d.size() > 0 ? hs2_d[0] : -1, 32'h00);
    check("t6_b1", hs2_d.size() > 1 ? hs2_d[1] : -1, 32'hFF);
    check("t6_b2", hs2_d.size() > 2 ? hs2_d[2] : -1, 32'h00);
    check("t6_b3", hs2_d.size() > 3 ? hs2_d[3] : -1, 32'hFF);
    check("t6_time0", hs2_t.size() > 0 ? hs2_t[0] : -1, n + LAT_D);
    check("t6_time1", hs2_t.size() > 1 ? hs2_t[1] : -1, n2 + LAT_D);
    check("t6_no_fe", fe2_t.size(), 0);
    check("t6_no_ov", ov2_t.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
